// File: rtl/lcd_frame_streamer_if.sv
// rtl/lcd_frame_streamer_if.sv - control, frame RAM and LCD pin bundle for lcd_frame_streamer
interface lcd_frame_streamer_if #(
  parameter int ADDR_W = 13
);
  logic              start;
  logic              continuous;
  logic              busy;
  logic              done;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              lcd_sck;
  logic              lcd_sdin;
  logic              lcd_dc;
  logic              lcd_sce;

  modport master (
    input  start, continuous, mem_data,
    output busy, done, mem_rd, mem_addr, lcd_sck, lcd_sdin, lcd_dc, lcd_sce
  );

  modport slave (
    output start, continuous, mem_data,
    input  busy, done, mem_rd, mem_addr, lcd_sck, lcd_sdin, lcd_dc, lcd_sce
  );
endinterface

// File: rtl/lcd_frame_streamer.sv
// rtl/lcd_frame_streamer.sv - streams command and pixel bytes from frame RAM to a PCD8544 over SPI
module lcd_frame_streamer #(
  parameter int ADDR_W  = 13,
  parameter int N_CMD   = 6,
  parameter int N_DATA  = 504,
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  lcd_frame_streamer_if.master bus
);
  localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [ADDR_W-1:0] CMD_END  = ADDR_W'(N_CMD);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_CMD + N_DATA - 1);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, SHIFT, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] index;
  logic [6:0]        shreg;
  logic [DIV_W-1:0]  div_cnt;
  logic [3:0]        half;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      index        <= '0;
      shreg        <= '0;
      div_cnt      <= '0;
      half         <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.mem_rd   <= 1'b0;
      bus.mem_addr <= '0;
      bus.lcd_sck  <= 1'b0;
      bus.lcd_sdin <= 1'b0;
      bus.lcd_dc   <= 1'b0;
      bus.lcd_sce  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            state        <= FETCH;
            index        <= '0;
            bus.mem_rd   <= 1'b1;
            bus.mem_addr <= '0;
            bus.lcd_sce  <= 1'b0;
            bus.busy     <= 1'b1;
          end
        end
        FETCH: begin
          bus.mem_rd <= 1'b0;
          state      <= WAIT;
        end
        WAIT: begin
          // dc is tied to the byte entering the shifter, not to the fetch address
          shreg        <= bus.mem_data[6:0];
          bus.lcd_sdin <= bus.mem_data[7];
          bus.lcd_dc   <= (index < CMD_END) ? 1'b0 : 1'b1;
          bus.lcd_sck  <= 1'b0;
          div_cnt      <= '0;
          half         <= '0;
          state        <= SHIFT;
        end
        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (half == 4'd15) begin
              bus.lcd_sck <= 1'b0;
              if (index < LAST_IDX) begin
                index        <= index + 1'b1;
                bus.mem_addr <= index + 1'b1;
                bus.mem_rd   <= 1'b1;
                state        <= FETCH;
              end else if (bus.continuous) begin
                index        <= CMD_END;
                bus.mem_addr <= CMD_END;
                bus.mem_rd   <= 1'b1;
                state        <= FETCH;
              end else begin
                bus.done <= 1'b1;
                state    <= DONE;
              end
            end else begin
              half <= half + 1'b1;
              if (!half[0]) begin
                bus.lcd_sck <= 1'b1;
              end else begin
                // next bit presented on the falling edge, stable for the next rise
                bus.lcd_sck  <= 1'b0;
                bus.lcd_sdin <= shreg[6];
                shreg        <= {shreg[5:0], 1'b0};
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        DONE: begin
          bus.done    <= 1'b0;
          bus.busy    <= 1'b0;
          bus.lcd_sce <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_frame_streamer.sv
// tb/tb_lcd_frame_streamer.sv - directed bench for lcd_frame_streamer
module tb_lcd_frame_streamer;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lcd_frame_streamer_if #(.ADDR_W(13)) ifa ();
  lcd_frame_streamer_if #(.ADDR_W(13)) ifb ();

  lcd_frame_streamer #(.ADDR_W(13), .N_CMD(6), .N_DATA(4), .CLK_DIV(2)) u_a (
    .clk(clk), .rst(rst), .bus(ifa.master));
  lcd_frame_streamer #(.ADDR_W(13), .N_CMD(6), .N_DATA(4), .CLK_DIV(1)) u_b (
    .clk(clk), .rst(rst), .bus(ifb.master));

  logic [7:0] ram [0:9] = '{8'h21, 8'hC8, 8'h06, 8'h13, 8'h20, 8'h0C, 8'hAA, 8'h55, 8'hFF, 8'h00};

  always @(posedge clk) begin
    if (ifa.mem_rd) ifa.mem_data <= ram[ifa.mem_addr[3:0]];
    if (ifb.mem_rd) ifb.mem_data <= ram[ifb.mem_addr[3:0]];
  end

  // pin monitor: decodes bytes on sck rise and logs reads, done pulses and timing violations
  logic       m_sck[2], m_sdin[2], m_dc[2], m_sce[2], m_busy[2], m_done[2], m_rd[2];
  int         m_addr[2];
  logic       p_sck[2], p_sdin[2], dc0[2];
  logic [7:0] acc[2];
  int         bit_cnt[2], last_rise[2];
  logic [7:0] rx_byte[2][64];
  logic       rx_dc[2][64];
  int         rx_n[2], rd_addr[2][64], rd_n[2], done_n[2], done_cyc[2];
  int         sce_viol[2], sdin_viol[2], dc_viol[2], per_viol[2];

  always @(negedge clk) begin
    m_sck[0] = ifa.lcd_sck; m_sdin[0] = ifa.lcd_sdin; m_dc[0] = ifa.lcd_dc; m_sce[0] = ifa.lcd_sce;
    m_busy[0] = ifa.busy; m_done[0] = ifa.done; m_rd[0] = ifa.mem_rd; m_addr[0] = int'(ifa.mem_addr);
    m_sck[1] = ifb.lcd_sck; m_sdin[1] = ifb.lcd_sdin; m_dc[1] = ifb.lcd_dc; m_sce[1] = ifb.lcd_sce;
    m_busy[1] = ifb.busy; m_done[1] = ifb.done; m_rd[1] = ifb.mem_rd; m_addr[1] = int'(ifb.mem_addr);
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        bit_cnt[i] = 0;
      end else begin
        if (m_rd[i]) begin
          if (rd_n[i] < 64) rd_addr[i][rd_n[i]] = m_addr[i];
          rd_n[i]++;
        end
        if (m_done[i]) begin
          done_n[i]++;
          done_cyc[i] = cyc;
        end
        if (m_busy[i] && m_sce[i]) sce_viol[i]++;
        if (m_sck[i] && (m_sdin[i] !== p_sdin[i])) sdin_viol[i]++;
        if (m_sck[i] && !p_sck[i]) begin
          if (bit_cnt[i] > 0 && (cyc - last_rise[i]) != ((i == 0) ? 4 : 2)) per_viol[i]++;
          last_rise[i] = cyc;
          if (bit_cnt[i] == 0) dc0[i] = m_dc[i];
          else if (m_dc[i] !== dc0[i]) dc_viol[i]++;
          acc[i] = {acc[i][6:0], m_sdin[i]};
          bit_cnt[i]++;
          if (bit_cnt[i] == 8) begin
            if (rx_n[i] < 64) begin
              rx_byte[i][rx_n[i]] = acc[i];
              rx_dc[i][rx_n[i]] = dc0[i];
            end
            rx_n[i]++;
            bit_cnt[i] = 0;
          end
        end
      end
      p_sck[i] = m_sck[i];
      p_sdin[i] = m_sdin[i];
    end
  end

  task automatic clear_logs();
    for (int i = 0; i < 2; i++) begin
      rx_n[i] = 0; rd_n[i] = 0; done_n[i] = 0; done_cyc[i] = 0; bit_cnt[i] = 0;
      sce_viol[i] = 0; sdin_viol[i] = 0; dc_viol[i] = 0; per_viol[i] = 0;
    end
  endtask

  task automatic send_start(input int which, output int t0);
    @(negedge clk);
    if (which == 0) ifa.start = 1'b1; else ifb.start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    ifa.start = 1'b0;
    ifb.start = 1'b0;
  endtask

  task automatic wait_done(input int which, input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk);
      if (done_n[which] >= n) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vecs++; if (ifa.busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b expected 0", ifa.busy); end
    vecs++; if (ifa.done !== 1'b0) begin errs++; $display("FAIL reset_done: got %b expected 0", ifa.done); end
    vecs++; if (ifa.mem_rd !== 1'b0) begin errs++; $display("FAIL reset_mem_rd: got %b expected 0", ifa.mem_rd); end
    vecs++; if (ifa.mem_addr !== 13'd0) begin errs++; $display("FAIL reset_mem_addr: got %0h expected 0", ifa.mem_addr); end
    vecs++; if ({ifa.lcd_sck, ifa.lcd_sdin, ifa.lcd_dc, ifa.lcd_sce} !== 4'b0001) begin
      errs++; $display("FAIL reset_pins: got sck/sdin/dc/sce=%b expected 0001",
                       {ifa.lcd_sck, ifa.lcd_sdin, ifa.lcd_dc, ifa.lcd_sce});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vecs++; if ({ifa.busy, ifa.lcd_sce} !== 2'b01) begin errs++; $display("FAIL idle_after_reset: got busy/sce=%b expected 01", {ifa.busy, ifa.lcd_sce}); end
  endtask

  task automatic test_frame();
    int t0;
    bit ok;
    @(posedge clk);
    clear_logs();
    send_start(0, t0);
    vecs++; if ({ifa.busy, ifa.mem_rd, ifa.lcd_sce} !== 3'b110) begin
      errs++; $display("FAIL frame_first_fetch: got busy/rd/sce=%b expected 110", {ifa.busy, ifa.mem_rd, ifa.lcd_sce});
    end
    wait_done(0, 1, 1000, ok);
    vecs++; if (!ok) begin errs++; $display("FAIL frame_done_timeout: got no done expected done"); end
    vecs++; if (done_cyc[0] - t0 != 340) begin errs++; $display("FAIL frame_done_time: got %0d expected 340", done_cyc[0] - t0); end
    vecs++; if (rx_n[0] != 10) begin errs++; $display("FAIL frame_byte_count: got %0d expected 10", rx_n[0]); end
    for (int b = 0; b < 10; b++) begin
      vecs++; if (rx_byte[0][b] !== ram[b]) begin errs++; $display("FAIL frame_byte%0d: got %0h expected %0h", b, rx_byte[0][b], ram[b]); end
      vecs++; if (rx_dc[0][b] !== (b >= 6)) begin errs++; $display("FAIL frame_dc%0d: got %b expected %b", b, rx_dc[0][b], (b >= 6)); end
      vecs++; if (rd_addr[0][b] != b) begin errs++; $display("FAIL frame_addr%0d: got %0d expected %0d", b, rd_addr[0][b], b); end
    end
    vecs++; if (dc_viol[0] != 0) begin errs++; $display("FAIL frame_dc_constant: got %0d changes expected 0", dc_viol[0]); end
    vecs++; if (sdin_viol[0] != 0) begin errs++; $display("FAIL frame_sdin_stable: got %0d changes expected 0", sdin_viol[0]); end
    vecs++; if (per_viol[0] != 0) begin errs++; $display("FAIL frame_sck_period: got %0d bad periods expected 0", per_viol[0]); end
    repeat (2) @(negedge clk);
    vecs++; if ({ifa.busy, ifa.lcd_sce} !== 2'b01) begin errs++; $display("FAIL frame_end_idle: got busy/sce=%b expected 01", {ifa.busy, ifa.lcd_sce}); end
    vecs++; if (done_n[0] != 1 || rd_n[0] != 10) begin errs++; $display("FAIL frame_counts: got done=%0d reads=%0d expected 1/10", done_n[0], rd_n[0]); end
  endtask

  task automatic test_continuous();
    int t0;
    bit ok;
    int exp_addr[14] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 6, 7, 8, 9};
    @(posedge clk);
    clear_logs();
    ifa.continuous = 1'b1;
    send_start(0, t0);
    ok = 1'b0;
    for (int k = 0; k < 2000 && !ok; k++) begin
      @(negedge clk);
      if (rd_n[0] >= 14) ok = 1'b1;
    end
    ifa.continuous = 1'b0;
    vecs++; if (!ok) begin errs++; $display("FAIL cont_reads_timeout: got %0d reads expected 14", rd_n[0]); end
    vecs++; if (done_n[0] != 0) begin errs++; $display("FAIL cont_no_done_between: got %0d expected 0", done_n[0]); end
    wait_done(0, 1, 1000, ok);
    repeat (3) @(negedge clk);
    vecs++; if (!ok || done_n[0] != 1) begin errs++; $display("FAIL cont_single_done: got %0d expected 1", done_n[0]); end
    vecs++; if (done_cyc[0] - t0 != 476) begin errs++; $display("FAIL cont_done_time: got %0d expected 476", done_cyc[0] - t0); end
    vecs++; if (rd_n[0] != 14) begin errs++; $display("FAIL cont_read_count: got %0d expected 14", rd_n[0]); end
    for (int b = 0; b < 14; b++) begin
      vecs++; if (rd_addr[0][b] != exp_addr[b]) begin errs++; $display("FAIL cont_addr%0d: got %0d expected %0d", b, rd_addr[0][b], exp_addr[b]); end
      vecs++; if (rx_byte[0][b] !== ram[exp_addr[b]]) begin errs++; $display("FAIL cont_byte%0d: got %0h expected %0h", b, rx_byte[0][b], ram[exp_addr[b]]); end
    end
    vecs++; if (sce_viol[0] != 0) begin errs++; $display("FAIL cont_sce_low: got %0d high cycles expected 0", sce_viol[0]); end
  endtask

  task automatic test_start_while_busy();
    int t0;
    bit ok;
    @(posedge clk);
    clear_logs();
    send_start(0, t0);
    ok = 1'b0;
    for (int k = 0; k < 500 && !ok; k++) begin
      @(negedge clk);
      if (rd_n[0] >= 4) ok = 1'b1;
    end
    repeat (10) @(negedge clk);
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 1000 && !ok; k++) begin
      @(negedge clk);
      if (ifa.done) ok = 1'b1;
    end
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    repeat (60) @(negedge clk);
    vecs++; if (!ok) begin errs++; $display("FAIL busy_done_timeout: got no done expected done"); end
    vecs++; if (done_n[0] != 1) begin errs++; $display("FAIL busy_done_count: got %0d expected 1", done_n[0]); end
    vecs++; if (rd_n[0] != 10) begin errs++; $display("FAIL busy_read_count: got %0d expected 10", rd_n[0]); end
    vecs++; if (done_cyc[0] - t0 != 340) begin errs++; $display("FAIL busy_done_time: got %0d expected 340", done_cyc[0] - t0); end
    vecs++; if ({ifa.busy, ifa.lcd_sce} !== 2'b01) begin errs++; $display("FAIL busy_end_idle: got busy/sce=%b expected 01", {ifa.busy, ifa.lcd_sce}); end
  endtask

  task automatic test_reset_mid_shift();
    int t0;
    bit ok;
    @(posedge clk);
    clear_logs();
    send_start(0, t0);
    ok = 1'b0;
    for (int k = 0; k < 1000 && !ok; k++) begin
      @(negedge clk);
      if (rd_n[0] >= 8) ok = 1'b1;
    end
    repeat (10) @(negedge clk);
    vecs++; if (ifa.lcd_dc !== 1'b1) begin errs++; $display("FAIL rst_pre_dc: got %b expected 1", ifa.lcd_dc); end
    rst = 1'b1;
    #1;
    vecs++; if ({ifa.lcd_sce, ifa.lcd_sck, ifa.lcd_dc, ifa.busy, ifa.mem_rd} !== 5'b10000) begin
      errs++; $display("FAIL rst_async: got sce/sck/dc/busy/rd=%b expected 10000",
                       {ifa.lcd_sce, ifa.lcd_sck, ifa.lcd_dc, ifa.busy, ifa.mem_rd});
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    clear_logs();
    send_start(0, t0);
    wait_done(0, 1, 1000, ok);
    vecs++; if (!ok) begin errs++; $display("FAIL rst_restart_timeout: got no done expected done"); end
    vecs++; if (rd_addr[0][0] != 0) begin errs++; $display("FAIL rst_restart_addr: got %0d expected 0", rd_addr[0][0]); end
    vecs++; if (rx_n[0] != 10 || rx_byte[0][0] !== 8'h21) begin errs++; $display("FAIL rst_restart_bytes: got n=%0d b0=%0h expected 10/21", rx_n[0], rx_byte[0][0]); end
    vecs++; if (done_cyc[0] - t0 != 340) begin errs++; $display("FAIL rst_restart_time: got %0d expected 340", done_cyc[0] - t0); end
  endtask

  task automatic test_clkdiv1();
    int t0;
    bit ok;
    @(posedge clk);
    clear_logs();
    send_start(1, t0);
    wait_done(1, 1, 500, ok);
    vecs++; if (!ok) begin errs++; $display("FAIL div1_done_timeout: got no done expected done"); end
    vecs++; if (done_cyc[1] - t0 != 180) begin errs++; $display("FAIL div1_done_time: got %0d expected 180", done_cyc[1] - t0); end
    vecs++; if (rx_n[1] != 10) begin errs++; $display("FAIL div1_byte_count: got %0d expected 10", rx_n[1]); end
    for (int b = 0; b < 10; b++) begin
      vecs++; if (rx_byte[1][b] !== ram[b] || rx_dc[1][b] !== (b >= 6)) begin
        errs++; $display("FAIL div1_byte%0d: got %0h dc=%b expected %0h dc=%b", b, rx_byte[1][b], rx_dc[1][b], ram[b], (b >= 6));
      end
    end
    vecs++; if (sdin_viol[1] != 0) begin errs++; $display("FAIL div1_sdin_stable: got %0d changes expected 0", sdin_viol[1]); end
    vecs++; if (per_viol[1] != 0) begin errs++; $display("FAIL div1_sck_period: got %0d bad periods expected 0", per_viol[1]); end
    vecs++; if (dc_viol[1] != 0) begin errs++; $display("FAIL div1_dc_constant: got %0d changes expected 0", dc_viol[1]); end
  endtask

  initial begin
    rst = 1'b1;
    ifa.start = 1'b0; ifa.continuous = 1'b0;
    ifb.start = 1'b0; ifb.continuous = 1'b0;
    clear_logs();
    test_reset();
    test_frame();
    test_continuous();
    test_start_while_busy();
    test_reset_mid_shift();
    test_clkdiv1();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
